// File: rtl/time_pkg.sv
// ============================================================================
// Module      : time_pkg
// Description : Mode encodings and BCD digit limits shared by the time counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package time_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_t;

    localparam logic [2:0] SEC_TENS_MAX   = 3'd5;
    localparam logic [3:0] ONES_MAX       = 4'd9;
    localparam logic [1:0] HOUR_TENS_MAX  = 2'd2;
    localparam logic [3:0] HOUR_WRAP_ONES = 4'd3;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Accepts a raw key level after it has been stable for
//               DEBOUNCE_CYCLES cycles and pulses once per accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50
) (
    input  logic Clock_5K,
    input  logic Reset,
    input  logic Key_In,
    output logic Key_Level,
    output logic Key_Press
);

    localparam logic [11:0] CNT_LAST = 12'(DEBOUNCE_CYCLES - 1);

    logic [11:0] r_cnt;
    logic        r_level;
    logic        r_press;

    always_ff @(posedge Clock_5K or negedge Reset) begin
        if (!Reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (Key_In == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // The differing level has now persisted for the full window.
                r_level <= Key_In;
                r_cnt   <= '0;
                r_press <= Key_In;
            end else begin
                r_cnt <= r_cnt + 12'd1;
            end
        end
    end

    assign Key_Level = r_level;
    assign Key_Press = r_press;

endmodule

`default_nettype wire

// File: rtl/time_counter.sv
// ============================================================================
// Module      : time_counter
// Description : 24-hour BCD time of day driven by a 1 Hz level input, with
//               debounced Mode/Inc keys for setting hours and minutes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_counter
    import time_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50
) (
    input  logic       Clock_5K,
    input  logic       Reset,
    input  logic       Clock_1Sec,
    input  logic       Mode_Key,
    input  logic       Inc_Key,
    output logic [1:0] Hour_Tens,
    output logic [3:0] Hour_Ones,
    output logic [2:0] Min_Tens,
    output logic [3:0] Min_Ones,
    output logic [2:0] Sec_Tens,
    output logic [3:0] Sec_Ones,
    output logic [1:0] Mode,
    output logic       Blink,
    output logic       Sec_Tick
);

    logic       w_mode_level, w_mode_raw_press, w_mode_press;
    logic       w_inc_level, w_inc_raw_press, w_inc_press;
    logic       w_tick;
    logic       w_min_step, w_hour_step, w_min_carry_en;
    logic       w_sec_tick_nxt;
    mode_t      r_mode, w_mode_nxt;
    logic       r_sec_prev, r_blink, r_sec_tick;
    logic [1:0] r_hour_t, w_hour_t_nxt;
    logic [3:0] r_hour_o, w_hour_o_nxt;
    logic [2:0] r_min_t, w_min_t_nxt;
    logic [3:0] r_min_o, w_min_o_nxt;
    logic [2:0] r_sec_t, w_sec_t_nxt;
    logic [3:0] r_sec_o, w_sec_o_nxt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
        .Clock_5K (Clock_5K),
        .Reset    (Reset),
        .Key_In   (Mode_Key),
        .Key_Level(w_mode_level),
        .Key_Press(w_mode_raw_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_key (
        .Clock_5K (Clock_5K),
        .Reset    (Reset),
        .Key_In   (Inc_Key),
        .Key_Level(w_inc_level),
        .Key_Press(w_inc_raw_press)
    );

    assign w_mode_press = w_mode_raw_press & w_mode_level;
    assign w_inc_press  = w_inc_raw_press & w_inc_level;
    assign w_tick       = Clock_1Sec & ~r_sec_prev;

    always_ff @(posedge Clock_5K or negedge Reset) begin
        if (!Reset) begin
            r_mode <= MODE_RUN;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (w_mode_press) begin
            case (r_mode)
                MODE_RUN:      w_mode_nxt = MODE_SET_HOUR;
                MODE_SET_HOUR: w_mode_nxt = MODE_SET_MIN;
                MODE_SET_MIN:  w_mode_nxt = MODE_RUN;
                default:       w_mode_nxt = MODE_RUN;
            endcase
        end
    end

    always_comb begin
        w_hour_t_nxt   = r_hour_t;
        w_hour_o_nxt   = r_hour_o;
        w_min_t_nxt    = r_min_t;
        w_min_o_nxt    = r_min_o;
        w_sec_t_nxt    = r_sec_t;
        w_sec_o_nxt    = r_sec_o;
        w_sec_tick_nxt = 1'b0;
        w_min_step     = 1'b0;
        w_hour_step    = 1'b0;
        w_min_carry_en = 1'b0;

        // A Mode press swallows any coincident tick or Inc press.
        if (w_mode_press) begin
            if (r_mode == MODE_SET_MIN) begin
                w_sec_t_nxt = '0;
                w_sec_o_nxt = '0;
            end
        end else begin
            case (r_mode)
                MODE_RUN: begin
                    if (w_tick) begin
                        w_sec_tick_nxt = 1'b1;
                        w_min_carry_en = 1'b1;
                        if (r_sec_o != ONES_MAX) begin
                            w_sec_o_nxt = r_sec_o + 4'd1;
                        end else begin
                            w_sec_o_nxt = '0;
                            if (r_sec_t != SEC_TENS_MAX) begin
                                w_sec_t_nxt = r_sec_t + 3'd1;
                            end else begin
                                w_sec_t_nxt = '0;
                                w_min_step  = 1'b1;
                            end
                        end
                    end
                end
                MODE_SET_HOUR: w_hour_step = w_inc_press;
                MODE_SET_MIN:  w_min_step  = w_inc_press;
                default: ;
            endcase
        end

        if (w_min_step) begin
            if (r_min_o != ONES_MAX) begin
                w_min_o_nxt = r_min_o + 4'd1;
            end else begin
                w_min_o_nxt = '0;
                if (r_min_t != SEC_TENS_MAX) begin
                    w_min_t_nxt = r_min_t + 3'd1;
                end else begin
                    w_min_t_nxt = '0;
                    w_hour_step = w_min_carry_en;
                end
            end
        end

        if (w_hour_step) begin
            if (r_hour_t == HOUR_TENS_MAX && r_hour_o == HOUR_WRAP_ONES) begin
                w_hour_t_nxt = '0;
                w_hour_o_nxt = '0;
            end else if (r_hour_o == ONES_MAX) begin
                w_hour_o_nxt = '0;
                w_hour_t_nxt = r_hour_t + 2'd1;
            end else begin
                w_hour_o_nxt = r_hour_o + 4'd1;
            end
        end
    end

    always_ff @(posedge Clock_5K or negedge Reset) begin
        if (!Reset) begin
            r_sec_prev <= 1'b0;
            r_blink    <= 1'b0;
            r_sec_tick <= 1'b0;
            r_hour_t   <= '0;
            r_hour_o   <= '0;
            r_min_t    <= '0;
            r_min_o    <= '0;
            r_sec_t    <= '0;
            r_sec_o    <= '0;
        end else begin
            r_sec_prev <= Clock_1Sec;
            r_blink    <= (r_mode != MODE_RUN) & Clock_1Sec;
            r_sec_tick <= w_sec_tick_nxt;
            r_hour_t   <= w_hour_t_nxt;
            r_hour_o   <= w_hour_o_nxt;
            r_min_t    <= w_min_t_nxt;
            r_min_o    <= w_min_o_nxt;
            r_sec_t    <= w_sec_t_nxt;
            r_sec_o    <= w_sec_o_nxt;
        end
    end

    assign Hour_Tens = r_hour_t;
    assign Hour_Ones = r_hour_o;
    assign Min_Tens  = r_min_t;
    assign Min_Ones  = r_min_o;
    assign Sec_Tens  = r_sec_t;
    assign Sec_Ones  = r_sec_o;
    assign Mode      = r_mode;
    assign Blink     = r_blink;
    assign Sec_Tick  = r_sec_tick;

endmodule

`default_nettype wire

// File: tb/tb_time_counter.sv
// ============================================================================
// Module      : tb_time_counter
// Description : Self-checking bench for time_counter: time-of-day model plus
//               directed key/seconds stimulus with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_counter;

    localparam int D = 50;

    logic       clk = 1'b0;
    logic       Reset;
    logic       c1s_manual, c1s_auto, r_auto;
    logic       Clock_1Sec;
    logic       Mode_Key, Inc_Key;
    logic [1:0] Hour_Tens;
    logic [3:0] Hour_Ones;
    logic [2:0] Min_Tens;
    logic [3:0] Min_Ones;
    logic [2:0] Sec_Tens;
    logic [3:0] Sec_Ones;
    logic [1:0] Mode;
    logic       Blink, Sec_Tick;

    int checks = 0;
    int errors = 0;
    int tick_count = 0;

    assign Clock_1Sec = c1s_auto ? r_auto : c1s_manual;

    always #5 clk = ~clk;

    time_counter #(.DEBOUNCE_CYCLES(D)) dut (
        .Clock_5K  (clk),
        .Reset     (Reset),
        .Clock_1Sec(Clock_1Sec),
        .Mode_Key  (Mode_Key),
        .Inc_Key   (Inc_Key),
        .Hour_Tens (Hour_Tens),
        .Hour_Ones (Hour_Ones),
        .Min_Tens  (Min_Tens),
        .Min_Ones  (Min_Ones),
        .Sec_Tens  (Sec_Tens),
        .Sec_Ones  (Sec_Ones),
        .Mode      (Mode),
        .Blink     (Blink),
        .Sec_Tick  (Sec_Tick)
    );

    // Free-running seconds square wave (3 cycles high, 3 low) for the set tests.
    int auto_cnt = 0;
    initial r_auto = 1'b0;
    always @(negedge clk) begin
        auto_cnt = (auto_cnt == 2) ? 0 : auto_cnt + 1;
        if (auto_cnt == 0) r_auto = ~r_auto;
    end

    always @(negedge clk) if (Reset === 1'b1 && Sec_Tick === 1'b1) tick_count++;

    // Behavioural model: time kept as plain hours/minutes/seconds integers.
    int m_h, m_m, m_s, m_mode, m_sod, m_mode_before;
    int m_cnt [2];
    bit m_acc [2];
    bit m_press [2];
    bit m_raw [2];
    bit m_prev, m_blink, m_stick, m_tick;

    always @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0;
            m_prev = 0; m_blink = 0; m_stick = 0;
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0; m_acc[k] = 0; m_press[k] = 0;
            end
        end else begin
            m_tick        = Clock_1Sec && !m_prev;
            m_mode_before = m_mode;
            m_stick       = 0;
            if (m_press[0]) begin
                if (m_mode == 2) m_s = 0;
                m_mode = (m_mode + 1) % 3;
            end else if (m_mode == 0 && m_tick) begin
                m_stick = 1;
                m_sod   = ((m_h * 60 + m_m) * 60 + m_s + 1) % 86400;
                m_h     = m_sod / 3600;
                m_m     = (m_sod / 60) % 60;
                m_s     = m_sod % 60;
            end else if (m_mode == 1 && m_press[1]) begin
                m_h = (m_h + 1) % 24;
            end else if (m_mode == 2 && m_press[1]) begin
                m_m = (m_m + 1) % 60;
            end
            m_blink   = (m_mode_before != 0) && Clock_1Sec;
            m_prev    = Clock_1Sec;
            m_raw[0]  = Mode_Key;
            m_raw[1]  = Inc_Key;
            for (int k = 0; k < 2; k++) begin
                m_press[k] = 0;
                if (m_raw[k] != m_acc[k]) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == D) begin
                        m_acc[k]   = m_raw[k];
                        m_cnt[k]   = 0;
                        m_press[k] = m_raw[k];
                    end
                end else begin
                    m_cnt[k] = 0;
                end
            end
        end
    end

    logic [23:0] exp_v, act_v;
    always @(negedge clk) begin
        if (Reset === 1'b1) begin
            exp_v = {2'(m_h / 10), 4'(m_h % 10), 3'(m_m / 10), 4'(m_m % 10),
                     3'(m_s / 10), 4'(m_s % 10), 2'(m_mode), m_blink, m_stick};
            act_v = {Hour_Tens, Hour_Ones, Min_Tens, Min_Ones, Sec_Tens, Sec_Ones,
                     Mode, Blink, Sec_Tick};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_state @%0t: got %h expected %h", $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        check({name, "_hour"}, int'(Hour_Tens) * 10 + int'(Hour_Ones), h);
        check({name, "_min"},  int'(Min_Tens) * 10 + int'(Min_Ones), m);
        check({name, "_sec"},  int'(Sec_Tens) * 10 + int'(Sec_Ones), s);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int which);
        if (which == 0) Mode_Key = 1'b1; else Inc_Key = 1'b1;
        cyc(D + 2);
        Mode_Key = 1'b0;
        Inc_Key  = 1'b0;
        cyc(D + 2);
    endtask

    task automatic presses(input int which, input int n);
        repeat (n) press(which);
    endtask

    task automatic tick_once();
        c1s_manual = 1'b1;
        cyc(2);
        c1s_manual = 1'b0;
        cyc(2);
    endtask

    int t0;
    logic seen;

    initial begin
        Reset = 1'b0; Mode_Key = 1'b0; Inc_Key = 1'b0;
        c1s_manual = 1'b0; c1s_auto = 1'b0;
        cyc(3);
        check_time("reset", 0, 0, 0);
        check("reset_mode", int'(Mode), 0);
        check("reset_blink_tick", int'({Blink, Sec_Tick}), 0);
        Reset = 1'b1;
        cyc(5);
        check_time("idle", 0, 0, 0);
        check("idle_ticks", tick_count, 0);

        c1s_manual = 1'b1;
        #1 check("pre_edge_sec", int'(Sec_Ones), 0);
        cyc(1);
        check("first_tick_sec", int'(Sec_Ones), 1);
        check("first_tick_pulse", int'(Sec_Tick), 1);
        cyc(2);
        c1s_manual = 1'b0;
        cyc(3);
        check("falling_no_tick", int'(Sec_Ones), 1);
        check("falling_tick_count", tick_count, 1);

        press(0);
        check("enter_set_hour", int'(Mode), 1);
        presses(1, 23);
        press(0);
        presses(1, 59);
        press(0);
        check_time("preload_set", 23, 59, 0);
        repeat (58) tick_once();
        check_time("preload", 23, 59, 58);

        t0 = tick_count;
        c1s_manual = 1'b1;
        cyc(1);
        check_time("edge1", 23, 59, 59);
        cyc(1);
        c1s_manual = 1'b0;
        cyc(2);
        c1s_manual = 1'b1;
        cyc(1);
        check_time("midnight", 0, 0, 0);
        cyc(1);
        c1s_manual = 1'b0;
        cyc(2);
        check("boundary_ticks", tick_count - t0, 2);

        Mode_Key = 1'b1; cyc(D - 1); Mode_Key = 1'b0; cyc(D + 5);
        check("hold_49", int'(Mode), 0);
        Mode_Key = 1'b1; cyc(D); Mode_Key = 1'b0; cyc(D + 5);
        check("hold_50", int'(Mode), 1);
        Mode_Key = 1'b1; cyc(24); Mode_Key = 1'b0; cyc(1); Mode_Key = 1'b1; cyc(25);
        cyc(2);
        check("glitch_hold", int'(Mode), 1);
        Mode_Key = 1'b0; cyc(D + 5);

        c1s_auto = 1'b1;
        presses(1, 25);
        check("hour_wrap", int'(Hour_Tens) * 10 + int'(Hour_Ones), 1);
        check("frozen_sec", int'(Sec_Tens) * 10 + int'(Sec_Ones), 0);
        for (int i = 0; i < 4; i++) begin
            #2 seen = Clock_1Sec;
            cyc(1);
            check("blink_follow", int'(Blink), int'(seen));
            cyc(i + 1);
        end
        press(0);
        presses(1, 58);
        check("min_58", int'(Min_Tens) * 10 + int'(Min_Ones), 58);
        presses(1, 2);
        check_time("min_wrap", 1, 0, 0);
        c1s_auto = 1'b0;
        cyc(2);

        press(0);
        press(0); presses(1, 11);
        press(0); presses(1, 34);
        press(0);
        repeat (27) tick_once();
        press(0); press(0);
        check("in_set_min", int'(Mode), 2);
        check_time("set_min_time", 12, 34, 27);
        press(0);
        check("exit_mode", int'(Mode), 0);
        check_time("exit_clear", 12, 34, 0);
        tick_once();
        check_time("resume", 12, 34, 1);

        Reset = 1'b0; cyc(1); Reset = 1'b1;
        press(0); presses(1, 5);
        press(0); presses(1, 6);
        press(0);
        repeat (7) tick_once();
        press(0);
        check_time("pre_reset", 5, 6, 7);
        check("pre_reset_mode", int'(Mode), 1);
        Inc_Key = 1'b1;
        cyc(30);
        Reset = 1'b0;
        #1 check_time("async_reset", 0, 0, 0);
        check("async_reset_mode", int'(Mode), 0);
        cyc(1);
        Reset = 1'b1;
        cyc(29);
        Inc_Key = 1'b0;
        cyc(D + 5);
        check_time("press_lost", 0, 0, 0);
        check("press_lost_mode", int'(Mode), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
